// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// a fixed-latency multiply/divide stall FSM with a saturating stall counter.
module hazard_unit #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MdStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdBusy,
  output logic [5:0]  MdCount,
  output logic [31:0] PerfStallCnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 2);

  md_state_t  state_q, state_d;
  logic [5:0] count_d;
  logic       md_done_q;
  logic       lw_stall;

  // Memory stage wins over Writeback because it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_comb begin
    state_d = state_q;
    count_d = MdCount;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    case (state_q)
      IDLE: begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushE = lw_stall || PCSrcE;
        FlushD = PCSrcE;
        // md_done_q blocks the still-present start of the op that just finished.
        if (MdStartE && !PCSrcE && !md_done_q) begin
          state_d = BUSY;
          count_d = MD_LOAD;
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
        end
      end
      BUSY: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        if (MdCount == 6'd0) state_d = IDLE;
        else                 count_d = MdCount - 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      MdCount      <= 6'd0;
      md_done_q    <= 1'b0;
      PerfStallCnt <= 32'd0;
    end else begin
      state_q   <= state_d;
      MdCount   <= count_d;
      md_done_q <= (state_q == BUSY) && (MdCount == 6'd0);
      if (StallF && (PerfStallCnt != 32'hFFFF_FFFF))
        PerfStallCnt <= PerfStallCnt + 32'd1;
    end
  end

  assign MdBusy = (state_q == BUSY);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected values are queued as each step is
// driven and popped when the corresponding output is sampled.
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [5:0]  MdCount;
  logic [31:0] PerfStallCnt;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int model_perf;
  int stall_cyc, busy_cyc, last_stall;

  hazard_unit #(.MD_LATENCY(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .MdCount(MdCount), .PerfStallCnt(PerfStallCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MdStartE = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_perf = 0;
    #12;
    push(0); chk("rst_busy", 32'(MdBusy));
    push(0); chk("rst_count", 32'(MdCount));
    push(0); chk("rst_perf", PerfStallCnt);
    push(0); chk("rst_stallf", 32'(StallF));
    rst_n = 1'b1;
    tick();

    // forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    push(2); push(2); #2;
    chk("fwdA_mem", 32'(ForwardAE));
    chk("fwdB_mem", 32'(ForwardBE));
    RdM = 0; push(1); #1; chk("fwdA_wb", 32'(ForwardAE));
    Rs1E = 0; push(0); #1; chk("fwdA_zero", 32'(ForwardAE));
    RdM = 9; RegWriteM = 1; RdW = 9; RegWriteW = 0; Rs2E = 9;
    push(2); #1; chk("fwdB_mem2", 32'(ForwardBE));
    RegWriteM = 0; push(0); #1; chk("fwdB_none", 32'(ForwardBE));
    clear_inputs();
    tick();

    // load-use hazard
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    push(1); push(1); push(1); push(0); #2;
    chk("lw_stallf", 32'(StallF));
    chk("lw_stalld", 32'(StallD));
    chk("lw_flushe", 32'(FlushE));
    chk("lw_stalle", 32'(StallE));
    tick(); model_perf += 1;
    ResultSrcE0 = 0; push(0); #2; chk("lw_release", 32'(StallF));
    ResultSrcE0 = 1; RdE = 0; Rs2D = 0; Rs1D = 0;
    push(0); #1; chk("lw_rd0", 32'(StallF));
    clear_inputs();
    tick();

    // branch beats multiply/divide start
    PCSrcE = 1; MdStartE = 1;
    push(1); push(1); push(0); #2;
    chk("br_md_flushd", 32'(FlushD));
    chk("br_md_flushe", 32'(FlushE));
    chk("br_md_stallf", 32'(StallF));
    tick();
    clear_inputs();
    push(0); #2; chk("br_md_busy", 32'(MdBusy));
    tick();

    // load-use together with branch
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    push(1); push(1); push(1); push(1); #2;
    chk("lwbr_stallf", 32'(StallF));
    chk("lwbr_stalld", 32'(StallD));
    chk("lwbr_flushe", 32'(FlushE));
    chk("lwbr_flushd", 32'(FlushD));
    tick(); model_perf += 1;
    clear_inputs();
    tick();

    // multiply/divide: start held through the first idle cycle afterwards
    stall_cyc = 0; busy_cyc = 0; last_stall = -1;
    MdStartE = 1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 4 && i <= 6) begin ResultSrcE0 = 1; RdE = 3; Rs1D = 3; PCSrcE = 1; end
      else begin ResultSrcE0 = 0; RdE = 0; Rs1D = 0; PCSrcE = 0; end
      #2;
      if (StallF) begin stall_cyc++; last_stall = i; end
      if (MdBusy) busy_cyc++;
      if (i == 1) begin push(30); chk("md_count_first", 32'(MdCount)); end
      if (i == 5) begin
        push(0); chk("md_busy_flushe", 32'(FlushE));
        push(0); chk("md_busy_flushd", 32'(FlushD));
        push(1); chk("md_busy_flushm", 32'(FlushM));
      end
      if (i == 32) MdStartE = 0;
      tick();
    end
    model_perf += 32;
    push(32); chk("md_stall_cycles", 32'(stall_cyc));
    push(31); chk("md_busy_cycles", 32'(busy_cyc));
    push(31); chk("md_last_stall", 32'(last_stall));
    push(32'(model_perf)); chk("perf_after_md", PerfStallCnt);
    clear_inputs();

    // reset in the middle of BUSY
    MdStartE = 1;
    tick();
    MdStartE = 0;
    repeat (20) tick();
    push(10); chk("md_count_10", 32'(MdCount));
    #2 rst_n = 1'b0;
    #1;
    model_perf = 0;
    push(0); chk("arst_busy", 32'(MdBusy));
    push(0); chk("arst_count", 32'(MdCount));
    push(32'(model_perf)); chk("arst_perf", PerfStallCnt);
    #2 rst_n = 1'b1;
    tick();
    push(0); push(0); push(0); #1;
    chk("post_rst_stallf", 32'(StallF));
    chk("post_rst_stalle", 32'(StallE));
    chk("post_rst_busy", 32'(MdBusy));
    tick();

    // saturating stall counter
    force dut.PerfStallCnt = 32'hFFFF_FFFD;
    #1 release dut.PerfStallCnt;
    ResultSrcE0 = 1; RdE = 4; Rs2D = 4;
    tick();
    push(32'hFFFF_FFFE); chk("perf_inc", PerfStallCnt);
    repeat (3) tick();
    push(32'hFFFF_FFFF); chk("perf_sat", PerfStallCnt);
    clear_inputs();
    tick();
    push(32'hFFFF_FFFF); chk("perf_hold", PerfStallCnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
